volcado_registros_ctrl: RTL and testbench

Debug-dump controller for the 32x32-bit register-read multiplexor. On command it takes ownership of the mux selector and steps through registers 0..N_REGS-1. It captures each selected 32-bit word and serialises it as 4 bytes over a valid/ready byte interface to the debug UART transmitter. While idle it passes the pipeline's own selector through unchanged, so the single mux is shared between normal datapath reads and debug dumps.

---
 rtl/volcado_registros_ctrl_if.sv | 23 ++
 rtl/volcado_registros_ctrl.sv | 129 ++++++++++++
 tb/tb_volcado_registros_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/volcado_registros_ctrl_if.sv
// Debug-dump bus: register-mux selector/data plus the byte stream to the UART transmitter.
//   selector  : mux selector driven by the dump controller
//   dato_mux  : 32-bit mux output, combinational from selector
//   tx_dato   : byte offered to the transmitter
//   tx_valido : tx_dato valid
//   tx_listo  : transmitter ready; a byte moves when tx_valido && tx_listo
interface volcado_registros_ctrl_if;
  logic [4:0]  selector;
  logic [31:0] dato_mux;
  logic [7:0]  tx_dato;
  logic        tx_valido;
  logic        tx_listo;

  modport master (
    output selector, tx_dato, tx_valido,
    input  dato_mux, tx_listo
  );

  modport slave (
    input  selector, tx_dato, tx_valido,
    output dato_mux, tx_listo
  );
endinterface

// File: rtl/volcado_registros_ctrl.sv
// Debug-dump controller: walks registers 0..N_REGS-1 through the shared read mux,
// captures each word and serialises it as 4 bytes on a valid/ready byte stream.
//   clk, rst_n   : clock, async active-low reset
//   inicio       : start a dump (only honoured when idle)
//   abortar      : synchronous abort, returns to idle without a fin pulse
//   sel_externo  : pipeline selector, forwarded to the mux while idle
//   dbg          : selector/dato_mux and tx_dato/tx_valido/tx_listo bus
//   ocupado      : high whenever a dump is in progress
//   fin          : one-cycle pulse after the last byte of a complete dump
module volcado_registros_ctrl #(
  parameter int unsigned N_REGS      = 32,
  parameter bit          MSB_PRIMERO = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            inicio,
  input  logic                            abortar,
  input  logic [4:0]                      sel_externo,
  volcado_registros_ctrl_if.master        dbg,
  output logic                            ocupado,
  output logic                            fin
);

  localparam int unsigned IDX_W = 5;
  localparam int unsigned CNT_W = 2;
  localparam logic [IDX_W-1:0] ULT_IDX = IDX_W'(N_REGS - 1);
  localparam logic [CNT_W-1:0] ULT_BYTE = CNT_W'(3);

  typedef enum logic [1:0] {IDLE, CAPTURA, ENVIO, FIN} estado_e;

  estado_e          estado_q, estado_d;
  logic [IDX_W-1:0] indice_q, indice_d;
  logic [CNT_W-1:0] cnt_byte_q, cnt_byte_d;
  logic [31:0]      palabra_q, palabra_d;
  logic             tx_valido_q, tx_valido_d;
  logic             ocupado_q, ocupado_d;
  logic             fin_q, fin_d;
  logic             transferencia;

  assign transferencia = tx_valido_q && dbg.tx_listo;

  // The output byte is always the leading byte of the shift register.
  assign dbg.tx_dato   = MSB_PRIMERO ? palabra_q[31:24] : palabra_q[7:0];
  assign dbg.tx_valido = tx_valido_q;
  // Both mux sources are registered, so the selector only changes right after an edge.
  assign dbg.selector  = ocupado_q ? indice_q : sel_externo;
  assign ocupado       = ocupado_q;
  assign fin           = fin_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= IDLE;
      indice_q    <= '0;
      cnt_byte_q  <= '0;
      palabra_q   <= '0;
      tx_valido_q <= 1'b0;
      ocupado_q   <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      indice_q    <= indice_d;
      cnt_byte_q  <= cnt_byte_d;
      palabra_q   <= palabra_d;
      tx_valido_q <= tx_valido_d;
      ocupado_q   <= ocupado_d;
      fin_q       <= fin_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    estado_d   = estado_q;
    indice_d   = indice_q;
    cnt_byte_d = cnt_byte_q;
    palabra_d  = palabra_q;

    case (estado_q)
      IDLE: begin
        if (inicio) begin
          estado_d   = CAPTURA;
          indice_d   = '0;
          cnt_byte_d = '0;
        end
      end
      CAPTURA: begin
        // selector has been stable for a full cycle, so the mux output is settled
        palabra_d = dbg.dato_mux;
        estado_d  = ENVIO;
      end
      ENVIO: begin
        if (transferencia) begin
          if (cnt_byte_q != ULT_BYTE) begin
            cnt_byte_d = cnt_byte_q + CNT_W'(1);
            palabra_d  = MSB_PRIMERO ? {palabra_q[23:0], 8'h00}
                                     : {8'h00, palabra_q[31:8]};
          end else if (indice_q != ULT_IDX) begin
            indice_d   = indice_q + IDX_W'(1);
            cnt_byte_d = '0;
            estado_d   = CAPTURA;
          end else begin
            estado_d = FIN;
          end
        end
      end
      FIN: begin
        estado_d = IDLE;
        indice_d = '0;
      end
      default: estado_d = IDLE;
    endcase

    // Abort overrides everything; in IDLE it also blocks a simultaneous inicio.
    if (abortar && (estado_q != IDLE)) begin
      estado_d   = IDLE;
      indice_d   = '0;
      cnt_byte_d = '0;
    end else if (abortar) begin
      estado_d   = IDLE;
      indice_d   = indice_q;
      cnt_byte_d = cnt_byte_q;
    end

    tx_valido_d = (estado_d == ENVIO);
    ocupado_d   = (estado_d != IDLE);
    fin_d       = (estado_d == FIN);
  end

endmodule

// File: tb/tb_volcado_registros_ctrl.sv
module tb_volcado_registros_ctrl;

  typedef struct packed {
    logic [4:0] sel;
    logic [7:0] dato;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ini_a = 1'b0, abo_a = 1'b0, ini_b = 1'b0, abo_b = 1'b0;
  logic [4:0] sel_a = 5'd0, sel_b = 5'd0;
  logic       ocu_a, fin_a, ocu_b, fin_b;
  logic [31:0] ent_a [32];
  logic [31:0] ent_b [32];

  volcado_registros_ctrl_if ifa ();
  volcado_registros_ctrl_if ifb ();

  assign ifa.dato_mux = ent_a[ifa.selector];
  assign ifb.dato_mux = ent_b[ifb.selector];

  volcado_registros_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .inicio(ini_a), .abortar(abo_a), .sel_externo(sel_a),
    .dbg(ifa), .ocupado(ocu_a), .fin(fin_a)
  );

  volcado_registros_ctrl #(.N_REGS(4), .MSB_PRIMERO(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .inicio(ini_b), .abortar(abo_b), .sel_externo(sel_b),
    .dbg(ifb), .ocupado(ocu_b), .fin(fin_b)
  );

  int   n_chk = 0;
  int   n_err = 0;
  int   edge_n = 0;
  int   e0 = 0;
  exp_t q_a [$];
  exp_t q_b [$];
  int   fin_cnt [2] = '{0, 0};
  int   nx      [2] = '{0, 0};
  int   last_x  [2] = '{0, 0};
  int   fin_e   [2] = '{0, 0};
  logic stall_p [2] = '{1'b0, 1'b0};
  logic [7:0] stall_d [2] = '{8'h00, 8'h00};

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected byte per handshake.
  task automatic mon(input int d, input logic v, input logic l, input logic [7:0] dat,
                     input logic [4:0] sel, input logic f, input logic ocu);
    exp_t e;
    bit   vacia;
    if (stall_p[d] && v) chk("stall_hold", 32'(dat), 32'(stall_d[d]));
    stall_p[d] = v && !l;
    stall_d[d] = dat;
    if (v && l) begin
      vacia = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
      n_chk++;
      if (vacia) begin
        n_err++;
        $display("FAIL unexpected_byte dut%0d: got %0h expected none", d, dat);
      end else begin
        if (d == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        if (dat !== e.dato || sel !== e.sel) begin
          n_err++;
          $display("FAIL byte dut%0d: got sel=%0d dato=%0h expected sel=%0d dato=%0h",
                   d, sel, dat, e.sel, e.dato);
        end
      end
      nx[d]++;
      last_x[d] = edge_n + 1;
    end
    if (f) begin
      fin_cnt[d]++;
      fin_e[d] = edge_n;
      chk("fin_with_ocupado", 32'(ocu), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_p[0] = 1'b0;
      stall_p[1] = 1'b0;
    end else begin
      mon(0, ifa.tx_valido, ifa.tx_listo, ifa.tx_dato, ifa.selector, fin_a, ocu_a);
      mon(1, ifb.tx_valido, ifb.tx_listo, ifb.tx_dato, ifb.selector, fin_b, ocu_b);
    end
  end

  // Reference model: each register contributes its four bytes in the configured order.
  task automatic push_dump(input int d, input int n, input bit msb);
    logic [31:0] w;
    exp_t        e;
    for (int r = 0; r < n; r++) begin
      w = (d == 0) ? ent_a[r] : ent_b[r];
      for (int k = 0; k < 4; k++) begin
        e.sel  = 5'(r);
        e.dato = 8'(w >> (8 * (msb ? (3 - k) : k)));
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int d);
    if (d == 0) ini_a = 1'b1; else ini_b = 1'b1;
    e0 = edge_n + 1;
    tick();
    ini_a = 1'b0;
    ini_b = 1'b0;
  endtask

  function automatic logic listo_pat(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (c % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_listo(input int d, input logic l);
    if (d == 0) ifa.tx_listo = l; else ifb.tx_listo = l;
  endtask

  task automatic wait_fin(input int d, input int mode, input int budget);
    int f0;
    int c;
    f0 = fin_cnt[d];
    c  = 0;
    while (fin_cnt[d] == f0 && c < budget) begin
      set_listo(d, listo_pat(mode, c));
      tick();
      c++;
    end
    chk("fin_seen", 32'(fin_cnt[d] - f0), 32'd1);
    chk("idle_after_fin", 32'((d == 0) ? ocu_a : ocu_b), 32'd0);
    set_listo(d, 1'b1);
    repeat (3) tick();
    chk("single_fin", 32'(fin_cnt[d] - f0), 32'd1);
    chk("queue_drained", (d == 0) ? 32'(q_a.size()) : 32'(q_b.size()), 32'd0);
  endtask

  task automatic fill_a();
    for (int i = 0; i < 32; i++) ent_a[i] = 32'hA500_0000 | 32'(i);
  endtask

  task automatic fill_b();
    for (int i = 0; i < 32; i++) ent_b[i] = 32'h1122_3300 | 32'(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int c;
    fill_a();
    fill_b();
    ifa.tx_listo = 1'b1;
    ifb.tx_listo = 1'b1;

    // Reset values and selector pass-through while reset is held
    for (int i = 0; i < 3; i++) begin
      sel_a = 5'($urandom_range(0, 31));
      #3;
      chk("rst_tx_valido", 32'(ifa.tx_valido), 32'd0);
      chk("rst_tx_dato", 32'(ifa.tx_dato), 32'd0);
      chk("rst_ocupado", 32'(ocu_a), 32'd0);
      chk("rst_fin", 32'(fin_a), 32'd0);
      chk("rst_selector", 32'(ifa.selector), 32'(sel_a));
    end
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_ocupado", 32'(ocu_a), 32'd0);

    // Full dump, no backpressure, with latency checks
    push_dump(0, 32, 1'b1);
    start(0);
    chk("captura_no_valid", 32'(ifa.tx_valido), 32'd0);
    chk("captura_ocupado", 32'(ocu_a), 32'd1);
    chk("captura_selector", 32'(ifa.selector), 32'd0);
    tick();
    chk("first_valid_e1", 32'(ifa.tx_valido), 32'd1);
    chk("first_byte", 32'(ifa.tx_dato), 32'hA5);
    wait_fin(0, 0, 400);
    chk("last_xfer_e160", 32'(last_x[0] - e0), 32'd160);
    chk("fin_after_e160", 32'(fin_e[0] - e0), 32'd160);

    // Backpressure 1-in-3
    push_dump(0, 32, 1'b1);
    start(0);
    wait_fin(0, 1, 1000);

    // Busy start and abort
    sel_a = 5'd19;
    push_dump(0, 5, 1'b1);
    for (int k = 0; k < 3; k++) q_a.push_back(exp_t'{5'd5, 8'(ent_a[5] >> (8 * (3 - k)))});
    n0 = nx[0];
    start(0);
    c = 0;
    while (nx[0] - n0 < 13 && c < 200) begin tick(); c++; end
    ini_a = 1'b1;
    tick();
    ini_a = 1'b0;
    c = 0;
    while (nx[0] - n0 < 22 && c < 200) begin tick(); c++; end
    chk("abort_pos_bytes", 32'(nx[0] - n0), 32'd22);
    n0 = fin_cnt[0];
    abo_a = 1'b1;
    tick();
    abo_a = 1'b0;
    chk("abort_ocupado", 32'(ocu_a), 32'd0);
    chk("abort_tx_valido", 32'(ifa.tx_valido), 32'd0);
    chk("abort_selector", 32'(ifa.selector), 32'd19);
    repeat (4) tick();
    chk("abort_no_fin", 32'(fin_cnt[0] - n0), 32'd0);
    chk("abort_bytes_drained", 32'(q_a.size()), 32'd0);
    push_dump(0, 32, 1'b1);
    start(0);
    tick();
    chk("restart_byte", 32'(ifa.tx_dato), 32'hA5);
    chk("restart_selector", 32'(ifa.selector), 32'd0);
    wait_fin(0, 0, 400);

    // Parameter variant: LSB first, 4 registers
    push_dump(1, 4, 1'b0);
    start(1);
    wait_fin(1, 0, 100);
    chk("b_last_xfer_e20", 32'(last_x[1] - e0), 32'd20);
    chk("b_fin_after_e20", 32'(fin_e[1] - e0), 32'd20);

    // Capture isolation: register 0 source changes after it was captured
    push_dump(1, 4, 1'b0);
    start(1);
    tick();
    ent_b[0] = 32'hFFFF_FFFF;
    wait_fin(1, 0, 100);
    fill_b();

    // Randomised words and random backpressure
    for (int i = 0; i < 32; i++) ent_a[i] = $urandom;
    sel_a = 5'($urandom_range(0, 31));
    push_dump(0, 32, 1'b1);
    start(0);
    wait_fin(0, 2, 2000);
    chk("idle_selector_rand", 32'(ifa.selector), 32'(sel_a));
    fill_a();

    // Asynchronous reset in the middle of ENVIO
    push_dump(0, 32, 1'b1);
    start(0);
    repeat (2) tick();
    chk("pre_reset_envio", 32'(ifa.tx_valido), 32'd1);
    sel_a = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valido", 32'(ifa.tx_valido), 32'd0);
    chk("async_rst_ocupado", 32'(ocu_a), 32'd0);
    chk("async_rst_fin", 32'(fin_a), 32'd0);
    chk("async_rst_selector", 32'(ifa.selector), 32'd7);
    q_a.delete();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 32'(ocu_a), 32'd0);
    chk("post_rst_tx_dato", 32'(ifa.tx_dato), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
